// File: rtl/ysyx_22050612_dmem_responder.sv
// ysyx_22050612_dmem_responder: fixed-latency 64-bit data memory responder with range checking
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   req_valid_i    request offered
//   req_ready_o    request accepted (IDLE only)
//   req_wen_i      1 = write, 0 = read
//   req_addr_i     byte address, low three bits ignored for indexing
//   req_wdata_i    lane-aligned write data
//   req_wmask_i    byte-lane write enables
//   resp_valid_o   response available (RESP only)
//   resp_ready_i   response consumed
//   resp_rdata_o   aligned read word, zero for writes and errors
//   resp_err_o     address out of range
module ysyx_22050612_dmem_responder #(
  parameter int          DEPTH_LOG2 = 8,
  parameter int          LATENCY    = 2,
  parameter logic [63:0] BASE       = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wen_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  input  logic [7:0]  req_wmask_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [63:0] resp_rdata_o,
  output logic        resp_err_o
);
  localparam logic [63:0] WORDS = 64'(1) << DEPTH_LOG2;
  localparam logic [3:0]  LAT1  = 4'(LATENCY - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wen_q, wen_d;
  logic [63:0]           addr_q, addr_d;
  logic [63:0]           wdata_q, wdata_d;
  logic [7:0]            wmask_q, wmask_d;
  logic [63:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [63:0]           mem_q [0:(1<<DEPTH_LOG2)-1];
  logic [63:0]           word_off;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  in_range;
  logic                  access;
  // addr >= BASE guards the subtraction so a wrapped offset is never accepted
  assign word_off = (addr_q - BASE) >> 3;
  assign in_range = (addr_q >= BASE) && (word_off < WORDS);
  assign idx      = word_off[DEPTH_LOG2-1:0];
  assign access   = (state_q == WAIT) && (cnt_q == 4'd0);
  assign req_ready_o  = state_q == IDLE;
  assign resp_valid_o = state_q == RESP;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        wen_d   = req_wen_i;
        addr_d  = req_addr_i;
        wdata_d = req_wdata_i;
        wmask_d = req_wmask_i;
        cnt_d   = LAT1;
        state_d = WAIT;
      end
      WAIT: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else begin
        // the read value is the word as stored before this edge; reads never write
        rdata_d = (!wen_q && in_range) ? mem_q[idx] : '0;
        err_d   = !in_range;
        state_d = RESP;
      end
      RESP: if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // storage is not reset; an asynchronous reset forces IDLE, which blocks the write edge
  always_ff @(posedge clk) begin
    if (access && wen_q && in_range)
      for (int i = 0; i < 8; i++)
        if (wmask_q[i]) mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
  end
endmodule

// File: doc/ysyx_22050612_dmem_responder.md
YSYX_22050612_DMEM_RESPONDER -- requirements
Module: ysyx_22050612_dmem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, means log2 of the word count of the 64-bit storage array (256 words).
REQ-002 Parameter LATENCY, default 2, means cycles from request acceptance to response valid; the legal range is 1..15.
REQ-003 Parameter BASE, default 64'h80000000, means the byte address of word 0.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  requester offers a transaction.
REQ-007 req_ready  output  1  responder accepts a transaction this cycle.
REQ-008 req_wen  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  64  byte address.
REQ-010 req_wdata  input  64  write data, already lane-aligned by the requester.
REQ-011 req_wmask  input  8  byte-lane write enables; bit i covers wdata[8i+7:8i].
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  requester consumes the response.
REQ-014 resp_rdata  output  64  full aligned read word, or 0 for writes and errors.
REQ-015 resp_err  output  1  address out of range.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP. The reset state SHALL be IDLE.
REQ-017 req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
REQ-018 IDLE: on req_valid&req_ready, the block SHALL capture wen, addr, wdata and wmask into internal registers, load the counter with LATENCY-1, and go to WAIT.
REQ-019 WAIT: while the counter is nonzero, it SHALL decrement. At counter==0, the block SHALL perform the access on that edge and go to RESP. resp_valid therefore rises LATENCY cycles after the acceptance edge.
REQ-020 RESP: the block SHALL hold resp_rdata and resp_err stable until resp_valid&resp_ready, then go to IDLE. A new request SHALL NOT be accepted in the same cycle as the response handshake.
REQ-021 Index SHALL be (addr-BASE)>>3. addr[2:0] SHALL be ignored for indexing; lane selection and sign extension are the requester's job.
REQ-022 The address is in range iff addr>=BASE and ((addr-BASE)>>3) < 2^DEPTH_LOG2, computed with 64-bit unsigned arithmetic and no wrap-around acceptance.
REQ-023 Out-of-range access: resp_err=1, resp_rdata=0, and no array write.
REQ-024 In-range write: for each i with wmask[i]=1, byte i of the word SHALL be replaced by wdata byte i. Other bytes are unchanged. resp_rdata=0 and resp_err=0.
REQ-025 A write with wmask=8'h00 SHALL change no storage but still complete with a normal response.
REQ-026 In-range read: resp_rdata SHALL be the stored word as of the access edge. A read following a write to the same word SHALL return the merged data.
REQ-027 Captured request fields SHALL NOT change while in WAIT or RESP, regardless of the req_* inputs.
REQ-028 resp_rdata and resp_err SHALL be registered outputs, with no combinational path from req_* to resp_*.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0; req_ready=1 follows from IDLE.
REQ-030 The storage array is not reset; its contents are undefined until written.
REQ-031 Reset asserted during WAIT before the access edge SHALL abort the transaction with no array write. No response SHALL follow after reset release.
REQ-032 Reset during RESP SHALL drop the pending response; the requester shall not see resp_valid again for that transaction.

Verification
REQ-033 Write 64'h1122334455667788, mask 8'hFF, addr 0x80000010; then read 0x80000010 -> resp_rdata=64'h1122334455667788, resp_err=0.
REQ-034 Same word, write wdata=64'hAABB000000000000, mask 8'hC0; read 0x80000014 -> 64'hAABB334455667788 (low address bits ignored).
REQ-035 LATENCY=2: request accepted at edge T -> resp_valid=1 from edge T+2. With resp_ready held 0 for 5 cycles -> outputs stable and req_ready=0 throughout.
REQ-036 Read 0x7FFFFFF8 and read BASE+8*256 -> resp_err=1, resp_rdata=0. A subsequent read of BASE -> resp_err=0.
REQ-037 Write 64'hFFFF... to BASE with reset pulsed 1 cycle after acceptance; after release, write 64'h5 to BASE, then read BASE -> 64'h5, and no spurious resp_valid after the pulse.
REQ-038 Write with wmask=0 to a word holding 64'h5 -> normal response, and a later read returns 64'h5.
